md_scheduler: RTL and testbench

Multi-cycle multiply/divide controller for the E stage of the five-stage pipeline. It accepts the MD operation and operands delivered by the D/E pipeline register, runs mult/div over a fixed number of busy cycles, owns the HI/LO registers, and raises the stall request that freezes D and bubbles the D/E register while an MD instruction in D would otherwise collide with a busy unit.

---
 rtl/md_scheduler.sv | 130 +++++++++++++
 tb/tb_md_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide controller for the E stage: owns HI/LO, sequences
// mult/div over a fixed busy window and raises the D-stage stall request.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDControl,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [1:0]  E_MDRead,
  input  logic        D_MDUse,
  output logic [31:0] E_MDOut,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;
  logic        is_mul, is_div;
  logic [63:0] res;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  // Truncating signed divide: quotient sign is the XOR of operand signs,
  // remainder takes the dividend's sign. Returns {remainder, quotient}.
  function automatic logic [63:0] sdivmod(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? 32'(-a) : 32'(a);
    ub = b[31] ? 32'(-b) : 32'(b);
    if (ub == 32'd0) return 64'd0;
    q = ua / ub;
    r = ua % ub;
    if (a[31] ^ b[31]) q = 32'(-q);
    if (a[31]) r = 32'(-r);
    return {r, q};
  endfunction

  function automatic logic [63:0] udivmod(input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  assign is_mul = (E_MDControl == 4'd1) || (E_MDControl == 4'd2);
  assign is_div = (E_MDControl == 4'd3) || (E_MDControl == 4'd4);

  assign prod_s = $signed(E_A) * $signed(E_B);
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  always_comb begin
    res = 64'd0;
    case (E_MDControl)
      4'd1:    res = prod_s;
      4'd2:    res = prod_u;
      4'd3:    res = sdivmod(E_A, E_B);
      4'd4:    res = udivmod(E_A, E_B);
      default: res = 64'd0;
    endcase
  end

  assign MD_Start = (is_mul || is_div) && (state == IDLE);
  assign MD_Busy  = (state == BUSY);
  assign MD_Stall = D_MDUse && (MD_Start || MD_Busy);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (MD_Start) begin
          state_nxt = BUSY;
          count_nxt = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end
      end
      BUSY: begin
        count_nxt = count - 4'd1;
        if (count == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A zero divisor still runs the full window but must not disturb HI/LO.
      if (MD_Start) begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_wr <= !(is_div && (E_B == 32'd0));
      end
      if (state == IDLE) begin
        if (E_MDControl == 4'd5) HI <= E_A;
        if (E_MDControl == 4'd6) LO <= E_A;
      end else if ((count == 4'd1) && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
  end

  always_comb begin
    case (E_MDRead)
      2'd1:    E_MDOut = HI;
      2'd2:    E_MDOut = LO;
      default: E_MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: vector table of MD operations with hand-derived
// HI/LO results, a scoreboard queue, and reset/stall corner sequences.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDControl;
  logic [31:0] E_A, E_B;
  logic [1:0]  E_MDRead;
  logic        D_MDUse;
  logic [31:0] E_MDOut, HI, LO;
  logic        MD_Start, MD_Busy, MD_Stall;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDControl(E_MDControl), .E_A(E_A), .E_B(E_B),
    .E_MDRead(E_MDRead), .D_MDUse(D_MDUse), .E_MDOut(E_MDOut),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_Stall(MD_Stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          busy;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          busy;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic proto_err = 1'b0;

  // Any MD op in E while the unit is busy means the stall protocol broke.
  always @(posedge clk)
    if (reset === 1'b1 && MD_Busy === 1'b1 && E_MDControl inside {[4'd1:4'd6]})
      proto_err <= 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_md(input vec_t v, input logic use_d);
    exp_t e;
    int   cyc;
    logic stall_ok;
    @(negedge clk);
    E_MDControl = v.op; E_A = v.a; E_B = v.b; D_MDUse = use_d; E_MDRead = 2'd0;
    #1;
    if (v.op inside {[4'd1:4'd4]}) begin
      check("start", MD_Start, 1);
      check("stall_t0", MD_Stall, use_d);
      e.hi = v.hi; e.lo = v.lo; e.busy = v.busy;
      sb.push_back(e);
      @(negedge clk);
      E_MDControl = 4'd0;
      #1;
      cyc = 0; stall_ok = 1'b1;
      while (MD_Busy === 1'b1 && cyc < 40) begin
        if (MD_Stall !== use_d) stall_ok = 1'b0;
        cyc++;
        @(negedge clk);
        #1;
      end
      e = sb.pop_front();
      check("stall_busy", stall_ok, 1);
      check("stall_after", MD_Stall, 0);
      check("busy_cycles", cyc, e.busy);
      check("hi", HI, e.hi);
      check("lo", LO, e.lo);
    end else begin
      check("start_mt", MD_Start, 0);
      @(negedge clk);
      E_MDControl = 4'd0; E_MDRead = 2'd1;
      #1;
      check("busy_mt", MD_Busy, 0);
      check("hi_mt", HI, v.hi);
      check("mdout_hi", E_MDOut, v.hi);
      E_MDRead = 2'd2; #1;
      check("mdout_lo", E_MDOut, v.lo);
      E_MDRead = 2'd3; #1;
      check("mdout_none", E_MDOut, 0);
      E_MDRead = 2'd0;
    end
  endtask

  initial begin
    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{4'd5, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
    vecs[4]  = '{4'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[5]  = '{4'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{4'd4, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8]  = '{4'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 5};
    vecs[9]  = '{4'd6, 32'h00001234, 32'd0,        32'h00000000, 32'h00001234, 0};
    vecs[10] = '{4'd5, 32'h00000055, 32'd0,        32'h00000055, 32'h00001234, 0};

    reset = 1'b0; E_MDControl = 4'd0; E_A = 32'd0; E_B = 32'd0;
    E_MDRead = 2'd0; D_MDUse = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", MD_Busy, 0);
    check("rst_stall", MD_Stall, 0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_md(vecs[i], 1'b1);

    // Non-MD instruction in D: never stalled while the unit is busy.
    run_md('{4'd1, 32'd5, 32'd7, 32'd0, 32'd35, 5}, 1'b0);

    // Asynchronous reset in the third busy cycle of a divide.
    @(negedge clk);
    E_MDControl = 4'd3; E_A = 32'd100; E_B = 32'd7; D_MDUse = 1'b1;
    @(negedge clk);
    E_MDControl = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_busy", MD_Busy, 1);
    #1 reset = 1'b0;
    #1;
    check("arst_hi", HI, 0);
    check("arst_lo", LO, 0);
    check("arst_busy", MD_Busy, 0);
    check("arst_stall", MD_Stall, 0);
    @(negedge clk);
    reset = 1'b1;
    run_md('{4'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5}, 1'b1);

    check("protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
